// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and iteration count for the EX-stage mul/div unit.
// Pure declarations; no logic, so no latency or flow control.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    localparam int         DIV_ITERS = 32;
    localparam logic [5:0] ITER_LAST = 6'(DIV_ITERS - 1);

endpackage

// File: rtl/ex_muldiv_unit_iter.sv
// One radix-2 step: shift-add multiply or restoring divide on a packed {rem, quo}/acc word.
// Purely combinational, zero latency; no flow control.
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  i_div,
    input  logic [2*DATA_W:0]     i_acc,
    input  logic [DATA_W-1:0]     i_opnd,
    output logic [2*DATA_W:0]     o_acc,
    output logic                  o_qbit
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W+1:0] w_shift;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W:0]   w_rem_nxt;
    logic              w_ge;

    // Multiply: acc = {product_hi, multiplier}; add on the LSB, then shift right.
    assign w_sum = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, (i_acc[0] ? i_opnd : {DATA_W{1'b0}})};

    // Divide: acc = {partial remainder (W+1), dividend/quotient (W)}.
    assign w_shift   = {i_acc[2*DATA_W:DATA_W], i_acc[DATA_W-1]};
    assign w_ge      = (w_shift >= {2'b00, i_opnd});
    assign w_diff    = w_shift[DATA_W:0] - {1'b0, i_opnd};
    assign w_rem_nxt = w_ge ? w_diff : w_shift[DATA_W:0];

    assign o_acc  = i_div ? {w_rem_nxt, i_acc[DATA_W-2:0], 1'b0}
                          : {1'b0, w_sum, i_acc[DATA_W-1:1]};
    assign o_qbit = i_div & w_ge;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; busy_o high 33 cycles, result visible the cycle after.
// No backpressure: busy_o stalls the pipeline and start_i is only honoured while idle.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [1:0]          r_state;
    logic [5:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_opnd;
    logic [2*DATA_W:0]   r_acc;
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_dz;

    logic                w_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_mag;
    logic [DATA_W-1:0]   w_rt_mag;
    logic [2*DATA_W:0]   w_acc_nxt;
    logic                w_qbit;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_signed = ~op_i[0];
    assign w_rs_neg = w_signed & rs_data_i[DATA_W-1];
    assign w_rt_neg = w_signed & rt_data_i[DATA_W-1];
    assign w_rs_mag = w_rs_neg ? -rs_data_i : rs_data_i;
    assign w_rt_mag = w_rt_neg ? -rt_data_i : rt_data_i;

    muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .i_div  (r_is_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_qbit (w_qbit)
    );

    // Divide-by-zero leaves the dividend magnitude in the remainder, so the
    // remainder sign fix alone restores the raw rs value for HI.
    assign w_prod = r_neg_res ? -r_acc[2*DATA_W-1:0] : r_acc[2*DATA_W-1:0];
    assign w_quo  = (r_neg_res && !r_dz) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        if (op_i[2] == 1'b0) begin
                            r_state   <= ST_RUN;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                            r_is_div  <= op_i[1];
                            r_opnd    <= op_i[1] ? w_rt_mag : w_rs_mag;
                            r_acc     <= {{(DATA_W+1){1'b0}}, (op_i[1] ? w_rs_mag : w_rt_mag)};
                            r_neg_res <= w_rs_neg ^ w_rt_neg;
                            r_neg_rem <= w_rs_neg;
                            r_dz      <= (rt_data_i == '0);
                        end else if (op_i == OP_MTHI) begin
                            r_hi   <= rs_data_i;
                            r_done <= 1'b1;
                        end else if (op_i == OP_MTLO) begin
                            r_lo   <= rs_data_i;
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_nxt | {{(2*DATA_W){1'b0}}, w_qbit};
                        if (r_cnt == ITER_LAST) begin
                            r_state <= ST_FIX;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush_i) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Table-driven bench for ex_muldiv_unit with an expected-result queue popped on done_o,
// plus hand-written flush, ignored-opcode and mid-operation reset sequences.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    exp_t sb [$];

    ex_muldiv_unit dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .op_i      (op),
        .rs_data_i (rs),
        .rt_data_i (rt),
        .flush_i   (flush),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && start)
            assert (!busy) else $error("FAIL protocol: start_i while busy_o");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   nb;
        int   g;
        exp_t e;
        op    = v.op;
        rs    = v.rs;
        rt    = v.rt;
        start = 1'b1;
        sb.push_back('{hi: v.hi, lo: v.lo});
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        g  = 0;
        while (!done && g < 60) begin
            if (busy) nb++;
            g++;
            @(negedge clk);
        end
        chk($sformatf("vec%0d busy_cycles", idx), nb, (v.op[2] ? 0 : 33));
        if (done) begin
            e = sb.pop_front();
            chk($sformatf("vec%0d hi", idx), hi, e.hi);
            chk($sformatf("vec%0d lo", idx), lo, e.lo);
            chk($sformatf("vec%0d busy_at_done", idx), {31'b0, busy}, 32'd0);
        end else begin
            checks++;
            failures++;
            $display("FAIL vec%0d timeout: got no done_o expected done_o within 60 cycles", idx);
        end
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{OP_MULT,  32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{OP_MULTU, 32'hFFFFFFFD, 32'd7,        32'd6,        32'hFFFFFFEB};
        vecs[12] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[14] = '{OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0};
        vecs[15] = '{OP_MTHI,  32'h00000011, 32'd0,        32'h00000011, 32'd0};
        vecs[16] = '{OP_MTLO,  32'h00000022, 32'd0,        32'h00000011, 32'h00000022};

        @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each vector issues on the negedge where the previous done_o is seen: back-to-back.
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        op = 3'b110; rs = 32'hABCD0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("op110 no_done%0d", i), {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        chk("op110 hi", hi, 32'h11);
        chk("op110 lo", lo, 32'h22);
        chk("op110 busy", {31'b0, busy}, 32'd0);

        op = OP_MTHI; rs = 32'hDEAD; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("idle_flush hi", hi, 32'h11);

        op = OP_MULT; rs = 32'd5; rt = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy_after", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                checks++;
                failures++;
                $display("FAIL flush stray_done: got done_o=1 expected 0 at cycle %0d", i);
            end
            @(negedge clk);
        end
        chk("flush hi", hi, 32'h11);
        chk("flush lo", lo, 32'h22);

        op = OP_MULT; rs = 32'd9; rt = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("rst busy_before", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst done", {31'b0, done}, 32'd0);
        @(negedge clk);

        run_vec('{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15}, 99);
        chk("scoreboard empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
